// File: rtl/apu_aout_sequencer.sv
// Audio-out lowpass filter timing controller.
// Divides clk down to the oversampled tick rate, strobes the FIR (en / en_shift),
// and pulls one mixer sample per 16-tick frame, holding the last sample on underflow.
module apu_aout_sequencer #(
    parameter int W_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [W_DIV-1:0] div,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    output logic             flt_en,
    output logic             flt_en_shift,
    output logic [15:0]      flt_d,
    output logic [3:0]       phase,
    output logic             underflow,
    input  logic             underflow_clr
);

    logic [W_DIV-1:0] div_ctr;
    logic [15:0]      last_sample;
    logic             tick;
    logic             shift_tick;
    logic             take;

    // Tick is gated by rst so every strobe is low while reset is held,
    // even though div_ctr sits at zero during reset.
    assign tick       = enable && !rst && (div_ctr == '0);
    assign shift_tick = tick && (phase == 4'd0);
    assign take       = shift_tick && s_valid;

    assign flt_en       = tick;
    assign flt_en_shift = shift_tick;
    assign s_ready      = shift_tick;
    // Zero-latency path: an accepted sample reaches the filter in its handshake cycle.
    assign flt_d        = take ? s_data : last_sample;

    // Down-counting divider; reload (with the current div) when idle or at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ctr <= '0;
        end else if (!enable || (div_ctr == '0)) begin
            div_ctr <= div;
        end else begin
            div_ctr <= div_ctr - W_DIV'(1);
        end
    end

    // Oversample phase; forced to 0 while idle so each enable starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 4'd0;
        end else if (!enable) begin
            phase <= 4'd0;
        end else if (tick) begin
            phase <= phase + 4'd1;
        end
    end

    // Capture the accepted sample so it can be repeated on underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sample <= 16'h0000;
        end else if (take) begin
            last_sample <= s_data;
        end
    end

    // Sticky underflow flag; a new underflow beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (shift_tick && !s_valid) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apu_aout_sequencer.sv
// Directed bench for apu_aout_sequencer.
module tb_apu_aout_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  div;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        flt_en;
    logic        flt_en_shift;
    logic [15:0] flt_d;
    logic [3:0]  phase;
    logic        underflow;
    logic        underflow_clr;

    int n_vec = 0;
    int n_err = 0;

    apu_aout_sequencer #(.W_DIV(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .div           (div),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .flt_en        (flt_en),
        .flt_en_shift  (flt_en_shift),
        .flt_d         (flt_d),
        .phase         (phase),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic        is_tick;
        logic        is_shift;
        logic [15:0] exp_last;
        logic        exp_uf;
        logic [3:0]  exp_phase;
        int          n_shift;

        rst = 1'b1; enable = 1'b0; div = 8'd3; s_valid = 1'b0;
        s_data = 16'h0000; underflow_clr = 1'b0;
        #12;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_flt_en", 32'(flt_en), 32'd0);
        chk("rst_shift", 32'(flt_en_shift), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_flt_d", 32'(flt_d), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        rst = 1'b0;
        cyc();
        cyc();
        s_valid = 1'b1;
        s_data  = 16'h1234;

        // div=3: ticks on cycles 4,8,12,...; shift ticks on cycles 4,68,132,196,260.
        exp_last = 16'h0000;
        exp_uf   = 1'b0;
        n_shift  = 0;
        for (int c = 1; c <= 286; c++) begin
            cyc();
            if (c == 1)   enable = 1'b1;
            if (c == 65)  s_data = 16'h8001;
            if (c == 129) s_data = 16'h0ABC;
            if (c == 133) s_valid = 1'b0;
            if (c == 201) underflow_clr = 1'b1;
            if (c == 202) underflow_clr = 1'b0;
            if (c == 259) underflow_clr = 1'b1;
            if (c == 261) underflow_clr = 1'b0;
            #1;
            is_tick   = (c % 4 == 0);
            is_shift  = (c % 64 == 4);
            exp_phase = 4'(((c - 1) / 4) % 16);
            chk($sformatf("flt_en c%0d", c), 32'(flt_en), 32'(is_tick));
            chk($sformatf("shift c%0d", c), 32'(flt_en_shift), 32'(is_shift));
            chk($sformatf("ready c%0d", c), 32'(s_ready), 32'(is_shift));
            chk($sformatf("phase c%0d", c), 32'(phase), 32'(exp_phase));
            chk($sformatf("uf c%0d", c), 32'(underflow), 32'(exp_uf));
            chk($sformatf("flt_d c%0d", c), 32'(flt_d),
                32'((is_shift && s_valid) ? s_data : exp_last));
            if (c == 4)   chk("hs_1234", 32'(flt_d), 32'h1234);
            if (c == 68)  chk("hs_8001", 32'(flt_d), 32'h8001);
            if (c == 196) chk("uf_hold_0abc", 32'(flt_d), 32'h0ABC);
            if (c == 197) chk("uf_set", 32'(underflow), 32'd1);
            if (c == 202) chk("uf_cleared", 32'(underflow), 32'd0);
            if (c == 261) chk("uf_set_wins", 32'(underflow), 32'd1);
            if (flt_en_shift) n_shift++;
            if (is_shift) begin
                if (s_valid) exp_last = s_data;
                else         exp_uf = 1'b1;
            end else if (underflow_clr) begin
                exp_uf = 1'b0;
            end
        end
        chk("shift_count", 32'(n_shift), 32'd5);
        chk("phase_before_disable", 32'(phase), 32'd7);

        // Disable mid-frame, then re-enable with div=0.
        enable = 1'b0;
        div    = 8'd0;
        #1;
        chk("dis_flt_en", 32'(flt_en), 32'd0);
        chk("dis_ready", 32'(s_ready), 32'd0);
        cyc();
        chk("dis_phase", 32'(phase), 32'd0);
        chk("dis_uf_kept", 32'(underflow), 32'd1);
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h5A5A;
        #1;
        chk("reen_flt_en", 32'(flt_en), 32'd1);
        chk("reen_shift", 32'(flt_en_shift), 32'd1);
        chk("reen_ready", 32'(s_ready), 32'd1);
        chk("reen_flt_d", 32'(flt_d), 32'h5A5A);
        chk("reen_phase", 32'(phase), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            #1;
            chk($sformatf("div0_en k%0d", k), 32'(flt_en), 32'd1);
            chk($sformatf("div0_shift k%0d", k), 32'(flt_en_shift), 32'd0);
            chk($sformatf("div0_phase k%0d", k), 32'(phase), 32'(k));
        end

        // Asynchronous reset between edges at phase 9.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_flt_en", 32'(flt_en), 32'd0);
        chk("arst_uf", 32'(underflow), 32'd0);
        chk("arst_ready", 32'(s_ready), 32'd0);
        chk("arst_flt_d", 32'(flt_d), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_en", 32'(flt_en), 32'd1);
        chk("post_rst_shift", 32'(flt_en_shift), 32'd1);
        chk("post_rst_flt_d", 32'(flt_d), 32'h5A5A);
        cyc();
        #1;
        chk("post_rst_phase", 32'(phase), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
